pixel_reader: RTL and testbench

PIXEL_READER -- requirements
Module: pixel_reader

---
 rtl/pixel_reader.sv | 196 +++++++++++++++++++
 tb/tb_pixel_reader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reader.sv
// pixel_reader: fetches one 8-bit pixel from a 256x192 byte-per-pixel frame buffer through a
// Spartan-6 MCB style command port and first-word-fall-through read port.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   pixel_en, pixel_x/_y     read request and coordinates (sampled only while idle)
//   pixel_rgb                colour of the last successfully read pixel
//   pixel_rd_done/_err       one-cycle completion / abort pulses
//   busy                     high whenever the reader is not idle
//   mem_cmd_*                MCB command port (always a single-word read)
//   mem_rd_*                 MCB read data port
//   cache_flush              invalidates the one-word cache
//
// Optional feature: define PIXEL_READER_CACHE_EN to add a one-word cache. Without it every
// request goes to memory and cache_flush is ignored.
module pixel_reader #(
  parameter logic [29:0] VRAM_BASE = 30'h0000000,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_en,
  input  logic [7:0]  pixel_x,
  input  logic [7:0]  pixel_y,
  output logic [7:0]  pixel_rgb,
  output logic        pixel_rd_done,
  output logic        pixel_rd_err,
  output logic        busy,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_empty,
  input  logic        mem_cmd_full,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_full,
  input  logic        mem_rd_empty,
  input  logic [6:0]  mem_rd_count,
  input  logic        mem_rd_overflow,
  input  logic        mem_rd_error,
  input  logic        cache_flush
);

  localparam logic [9:0] TimeoutCnt = 10'(TIMEOUT);

  typedef enum logic [2:0] {StFlush, StIdle, StCmd, StWait, StDone} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_x, r_y;
  logic [9:0]  r_wait_cnt;
  logic [7:0]  r_pixel_rgb;

  logic [29:0] w_byte_addr;
  logic [7:0]  w_rd_byte;
  logic        w_hit;
  logic [7:0]  w_cache_byte;
  logic        w_cmd_en, w_rd_en, w_rd_err, w_capture, w_hit_take;

  // Word-aligned address; the sum wraps naturally at 30 bits.
  assign w_byte_addr = VRAM_BASE + {14'd0, r_y, r_x[7:2], 2'b00};

  always_comb begin
    w_rd_byte = mem_rd_data[7:0];
    case (r_x[1:0])
      2'd0:    w_rd_byte = mem_rd_data[7:0];
      2'd1:    w_rd_byte = mem_rd_data[15:8];
      2'd2:    w_rd_byte = mem_rd_data[23:16];
      default: w_rd_byte = mem_rd_data[31:24];
    endcase
  end

`ifdef PIXEL_READER_CACHE_EN
  logic        r_cache_valid;
  logic [27:0] r_cache_addr;
  logic [31:0] r_cache_data;
  logic [29:0] w_req_addr;
  logic        w_unused;

  // Hit is judged on the live request coordinates so a hit can complete in one cycle.
  assign w_req_addr = VRAM_BASE + {14'd0, pixel_y, pixel_x[7:2], 2'b00};
  // A flush arriving with the request wins over a stale hit.
  assign w_hit = r_cache_valid && !cache_flush && (r_cache_addr == w_req_addr[29:2]);

  always_comb begin
    w_cache_byte = r_cache_data[7:0];
    case (pixel_x[1:0])
      2'd0:    w_cache_byte = r_cache_data[7:0];
      2'd1:    w_cache_byte = r_cache_data[15:8];
      2'd2:    w_cache_byte = r_cache_data[23:16];
      default: w_cache_byte = r_cache_data[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cache_valid <= 1'b0;
      r_cache_addr  <= '0;
      r_cache_data  <= '0;
    end else if (cache_flush) begin
      r_cache_valid <= 1'b0;
    end else if (w_capture) begin
      r_cache_valid <= 1'b1;
      r_cache_addr  <= w_byte_addr[29:2];
      r_cache_data  <= mem_rd_data;
    end
  end

  assign w_unused = ^{mem_rd_full, mem_rd_count, w_req_addr[1:0]};
`else
  logic w_unused;

  assign w_hit        = 1'b0;
  assign w_cache_byte = 8'h00;
  assign w_unused     = ^{mem_rd_full, mem_rd_count, cache_flush};
`endif

  always_comb begin
    w_state_next = r_state;
    w_cmd_en     = 1'b0;
    w_rd_en      = 1'b0;
    w_rd_err     = 1'b0;
    w_capture    = 1'b0;
    w_hit_take   = 1'b0;
    case (r_state)
      StFlush: begin
        // Drain anything left in the read FIFO until both MCB queues are idle.
        w_rd_en = !mem_rd_empty;
        if (mem_rd_empty && mem_cmd_empty) w_state_next = StIdle;
      end
      StIdle: begin
        if (pixel_en) begin
          if (w_hit) begin
            w_hit_take   = 1'b1;
            w_state_next = StDone;
          end else begin
            w_state_next = StCmd;
          end
        end
      end
      StCmd: begin
        if (!mem_cmd_full) begin
          w_cmd_en     = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        // Fault beats data, data beats timeout.
        if (mem_rd_error || mem_rd_overflow) begin
          w_rd_err     = 1'b1;
          w_state_next = StFlush;
        end else if (!mem_rd_empty) begin
          w_rd_en      = 1'b1;
          w_capture    = 1'b1;
          w_state_next = StDone;
        end else if (r_wait_cnt == TimeoutCnt) begin
          w_rd_err     = 1'b1;
          w_state_next = StFlush;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StFlush;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StFlush;
      r_x         <= '0;
      r_y         <= '0;
      r_wait_cnt  <= '0;
      r_pixel_rgb <= 8'h00;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && pixel_en) begin
        r_x <= pixel_x;
        r_y <= pixel_y;
      end
      r_wait_cnt <= (r_state == StWait) ? r_wait_cnt + 10'd1 : 10'd0;
      if (w_capture)  r_pixel_rgb <= w_rd_byte;
      if (w_hit_take) r_pixel_rgb <= w_cache_byte;
    end
  end

  // Strobes are gated by rst so nothing leaks out while reset is held mid-transaction.
  assign pixel_rgb         = r_pixel_rgb;
  assign pixel_rd_done     = (r_state == StDone) && !rst;
  assign pixel_rd_err      = w_rd_err && !rst;
  assign busy              = rst || (r_state != StIdle);
  assign mem_cmd_en        = w_cmd_en && !rst;
  assign mem_rd_en         = w_rd_en && !rst;
  assign mem_cmd_instr     = 3'b001;
  assign mem_cmd_bl        = 6'd0;
  assign mem_cmd_byte_addr = w_byte_addr;

endmodule

// File: tb/tb_pixel_reader.sv
module tb_pixel_reader;

  localparam logic [29:0] BASE = 30'h0000000;
  localparam int unsigned TO   = 8;

  logic        clk = 1'b0;
  logic        rst, pixel_en, cache_flush;
  logic [7:0]  pixel_x, pixel_y, pixel_rgb;
  logic        pixel_rd_done, pixel_rd_err, busy;
  logic        mem_cmd_en, mem_cmd_empty, mem_cmd_full;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_rd_en, mem_rd_full, mem_rd_empty, mem_rd_overflow, mem_rd_error;
  logic [31:0] mem_rd_data;
  logic [6:0]  mem_rd_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] last_rgb;

  always #5 clk = ~clk;

  pixel_reader #(.VRAM_BASE(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_rgb(pixel_rgb), .pixel_rd_done(pixel_rd_done), .pixel_rd_err(pixel_rd_err),
    .busy(busy), .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr),
    .mem_cmd_bl(mem_cmd_bl), .mem_cmd_byte_addr(mem_cmd_byte_addr),
    .mem_cmd_empty(mem_cmd_empty), .mem_cmd_full(mem_cmd_full), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_rd_full(mem_rd_full), .mem_rd_empty(mem_rd_empty),
    .mem_rd_count(mem_rd_count), .mem_rd_overflow(mem_rd_overflow),
    .mem_rd_error(mem_rd_error), .cache_flush(cache_flush)
  );

  typedef struct {
    logic [7:0]  x;
    logic [7:0]  y;
    logic [31:0] word;
    int          delay;
    int          full;
    logic [29:0] addr;
    logic [7:0]  rgb;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: frame buffer is row-major, 256 bytes per row, little-endian words.
  function automatic logic [29:0] model_addr(input int x, input int y);
    longint a;
    a = longint'(BASE) + longint'(y) * 256 + longint'(x / 4) * 4;
    return 30'(a % 64'h4000_0000);
  endfunction

  function automatic logic [7:0] model_byte(input logic [31:0] w, input int x);
    return 8'((w >> (8 * (x % 4))) & 32'hFF);
  endfunction

  // Request from IDLE and accept the command immediately; returns at WAIT cycle 0.
  task automatic issue_cmd(input logic [7:0] x, input logic [7:0] y);
    pixel_x = x; pixel_y = y; pixel_en = 1'b1; cache_flush = 1'b1;
    #1 check("req_idle", busy, 0);
    @(negedge clk);
    pixel_en = 1'b0; cache_flush = 1'b0;
    #1 check("cmd_en", mem_cmd_en, 1);
    check("cmd_addr", mem_cmd_byte_addr, model_addr(x, y));
    @(negedge clk);
  endtask

  // Full miss transaction with command back-pressure and read latency; ends in IDLE.
  task automatic read_txn(input logic [7:0] x, input logic [7:0] y, input logic [31:0] word,
                          input int delay, input int full, input logic flush,
                          input logic [29:0] exp_addr, input logic [7:0] exp_rgb);
    pixel_x = x; pixel_y = y; pixel_en = 1'b1; cache_flush = flush;
    #1 check("req_idle", busy, 0);
    @(negedge clk);
    pixel_en = 1'b0; cache_flush = 1'b0; mem_cmd_full = (full > 0);
    for (int i = 0; i < full; i++) begin
      #1 check("cmd_held", mem_cmd_en, 0);
      check("cmd_busy", busy, 1);
      @(negedge clk);
    end
    mem_cmd_full = 1'b0;
    #1 check("cmd_en", mem_cmd_en, 1);
    check("cmd_addr", mem_cmd_byte_addr, exp_addr);
    check("cmd_instr_bl", {mem_cmd_instr, mem_cmd_bl}, {3'b001, 6'd0});
    @(negedge clk);
    // Requests during WAIT must be ignored.
    pixel_en = 1'b1; pixel_x = ~x; pixel_y = ~y;
    for (int i = 0; i < delay; i++) begin
      #1 check("wait_no_rd", {mem_rd_en, mem_cmd_en, pixel_rd_err, pixel_rd_done}, 0);
      @(negedge clk);
    end
    pixel_en = 1'b0;
    mem_rd_empty = 1'b0; mem_rd_data = word;
    #1 check("rd_en", mem_rd_en, 1);
    check("rd_no_done", pixel_rd_done, 0);
    @(negedge clk);
    mem_rd_empty = 1'b1; mem_rd_data = $urandom;
    #1 check("done", pixel_rd_done, 1);
    check("rgb", pixel_rgb, exp_rgb);
    check("done_no_err_rd", {pixel_rd_err, mem_rd_en}, 0);
    @(negedge clk);
    #1 check("idle_after", {busy, pixel_rd_done}, 0);
    last_rgb = exp_rgb;
  endtask

  initial begin
    vecs[0] = '{8'd127, 8'd95,  32'hAABBCCDD, 1, 0, 30'h5F7C, 8'hAA};
    vecs[1] = '{8'd0,   8'd0,   32'h11223344, 0, 0, 30'h0000, 8'h44};
    vecs[2] = '{8'd255, 8'd191, 32'hDEADBEEF, 3, 5, 30'hBFFC, 8'hDE};
    vecs[3] = '{8'd5,   8'd1,   32'hCAFEF00D, 8, 0, 30'h0104, 8'hF0};
    vecs[4] = '{8'd2,   8'd10,  32'h12345678, 2, 1, 30'h0A00, 8'h34};

    rst = 1'b1; pixel_en = 1'b0; pixel_x = '0; pixel_y = '0; cache_flush = 1'b0;
    mem_cmd_empty = 1'b1; mem_cmd_full = 1'b0; mem_rd_full = 1'b0; mem_rd_empty = 1'b0;
    mem_rd_overflow = 1'b0; mem_rd_error = 1'b0; mem_rd_data = 32'h0; mem_rd_count = '0;

    // Reset state, with read data pending so a leaky mem_rd_en would show.
    @(negedge clk);
    #1 check("rst_busy", busy, 1);
    check("rst_rgb", pixel_rgb, 8'h00);
    check("rst_strobes", {pixel_rd_done, pixel_rd_err, mem_cmd_en, mem_rd_en}, 0);
    @(negedge clk);
    rst = 1'b0; mem_rd_empty = 1'b1;
    #1 check("flush_busy", busy, 1);
    @(negedge clk);
    #1 check("idle", busy, 0);
    last_rgb = 8'h00;

    for (int i = 0; i < 5; i++)
      read_txn(vecs[i].x, vecs[i].y, vecs[i].word, vecs[i].delay, vecs[i].full, 1'b1,
               vecs[i].addr, vecs[i].rgb);

    // Timeout: no data for TIMEOUT cycles, then a late word drained in FLUSH.
    issue_cmd(8'd10, 8'd20);
    for (int c = 0; c < int'(TO); c++) begin
      #1 check("to_no_err", pixel_rd_err, 0);
      @(negedge clk);
    end
    #1 check("to_err", pixel_rd_err, 1);
    check("to_no_done", {pixel_rd_done, mem_rd_en}, 0);
    @(negedge clk);
    mem_rd_empty = 1'b0; mem_rd_data = 32'h99999999;
    #1 check("to_drain", mem_rd_en, 1);
    check("to_busy", busy, 1);
    check("to_rgb_kept", pixel_rgb, last_rgb);
    @(negedge clk);
    mem_rd_empty = 1'b1; mem_cmd_empty = 1'b0;
    #1 check("to_wait_cmdq", {busy, mem_rd_en}, 2'b10);
    @(negedge clk);
    mem_cmd_empty = 1'b1;
    #1 check("to_still_busy", busy, 1);
    @(negedge clk);
    #1 check("to_idle", busy, 0);
    check("to_rgb_final", pixel_rgb, last_rgb);

    // Read error / overflow with data present: abort, no capture.
    for (int k = 0; k < 2; k++) begin
      issue_cmd(8'd3, 8'd3);
      mem_rd_empty = 1'b0; mem_rd_data = 32'h5A5A5A5A;
      mem_rd_error = (k == 0); mem_rd_overflow = (k == 1);
      #1 check("fault_err", pixel_rd_err, 1);
      check("fault_no_rd", {mem_rd_en, pixel_rd_done}, 0);
      @(negedge clk);
      mem_rd_error = 1'b0; mem_rd_overflow = 1'b0;
      #1 check("fault_drain", mem_rd_en, 1);
      check("fault_no_done", {pixel_rd_done, pixel_rd_err}, 0);
      check("fault_rgb_kept", pixel_rgb, last_rgb);
      @(negedge clk);
      mem_rd_empty = 1'b1;
      #1 check("fault_busy", busy, 1);
      @(negedge clk);
      #1 check("fault_idle", busy, 0);
    end

    // Reset mid-read, then a stale word arrives.
    issue_cmd(8'd7, 8'd7);
    rst = 1'b1;
    #1 check("mid_rst_busy", busy, 1);
    check("mid_rst_strobes", {mem_rd_en, mem_cmd_en, pixel_rd_err, pixel_rd_done}, 0);
    @(negedge clk);
    rst = 1'b0; mem_rd_empty = 1'b0; mem_rd_data = 32'h77777777;
    #1 check("stale_drain", mem_rd_en, 1);
    check("stale_busy", busy, 1);
    check("stale_rgb_rst", pixel_rgb, 8'h00);
    last_rgb = 8'h00;
    @(negedge clk);
    mem_rd_empty = 1'b1; mem_cmd_empty = 1'b0;
    #1 check("stale_cmdq_busy", busy, 1);
    @(negedge clk);
    mem_cmd_empty = 1'b1;
    #1 check("stale_last_busy", busy, 1);
    @(negedge clk);
    #1 check("stale_idle", busy, 0);

`ifdef PIXEL_READER_CACHE_EN
    // Same word twice: second is a hit with no command; after a flush it misses again.
    read_txn(8'd4, 8'd3, 32'hA1B2C3D4, 1, 0, 1'b1, model_addr(4, 3), model_byte(32'hA1B2C3D4, 4));
    pixel_x = 8'd6; pixel_y = 8'd3; pixel_en = 1'b1;
    #1 check("hit_no_cmd", mem_cmd_en, 0);
    @(negedge clk);
    pixel_en = 1'b0;
    #1 check("hit_done", pixel_rd_done, 1);
    check("hit_rgb", pixel_rgb, model_byte(32'hA1B2C3D4, 6));
    check("hit_no_mem", {mem_cmd_en, mem_rd_en}, 0);
    @(negedge clk);
    cache_flush = 1'b1;
    #1 check("hit_idle", busy, 0);
    @(negedge clk);
    cache_flush = 1'b0;
    read_txn(8'd6, 8'd3, 32'h0F1E2D3C, 2, 0, 1'b0, model_addr(6, 3), model_byte(32'h0F1E2D3C, 6));
`else
    // Without the cache the same word is always fetched again.
    read_txn(8'd4, 8'd3, 32'hA1B2C3D4, 1, 0, 1'b0, model_addr(4, 3), model_byte(32'hA1B2C3D4, 4));
    read_txn(8'd6, 8'd3, 32'h0F1E2D3C, 0, 0, 1'b0, model_addr(6, 3), model_byte(32'h0F1E2D3C, 6));
`endif

    // Randomized transactions against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  rx, ry;
      logic [31:0] rw;
      rx = 8'($urandom_range(0, 255));
      ry = 8'($urandom_range(0, 191));
      rw = $urandom;
      read_txn(rx, ry, rw, int'($urandom_range(0, TO)), int'($urandom_range(0, 3)), 1'b1,
               model_addr(int'(rx), int'(ry)), model_byte(rw, int'(rx)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
